// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of N leaky integrate-and-fire neurons.
// Ports: clk, rst_n (sync, active-low); step_start starts a timestep;
// cur_valid/cur_ready/cur_data stream one current per neuron in index
// order (cur_idx); busy while running; step_done pulses with spikes and
// spike_count; rd_idx/rd_potential give a combinational debug read.
// Optional refractory period: define LIF_REFRACTORY_EN.
module lif_neuron_array #(
  parameter int N_NEURONS    = 16,
  parameter int WIDTH        = 16,
  parameter int THRESHOLD    = 1000,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2,
  localparam int IDX_W       = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_start,
  input  logic                    cur_valid,
  output logic                    cur_ready,
  input  logic signed [WIDTH-1:0] cur_data,
  output logic                    busy,
  output logic [IDX_W-1:0]        cur_idx,
  output logic                    step_done,
  output logic [N_NEURONS-1:0]    spikes,
  output logic [IDX_W:0]          spike_count,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [WIDTH-1:0] rd_potential
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_NEURONS - 1);
  localparam logic signed [WIDTH:0] THR =
    (WIDTH+1)'(THRESHOLD);

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [N_NEURONS-1:0]    acc;
  logic signed [WIDTH-1:0] pot [N_NEURONS];

  logic                    hs;
  logic                    in_refr;
  logic                    fire;
  logic signed [WIDTH:0]   p_ext;
  logic signed [WIDTH:0]   c_ext;
  logic signed [WIDTH:0]   calc;
  logic signed [WIDTH-1:0] p_new;
  logic [N_NEURONS-1:0]    acc_next;
  logic [IDX_W:0]          cnt;

  assign cur_ready = (state == RUN);
  assign busy      = (state == RUN);
  assign cur_idx   = ptr;
  assign hs        = cur_valid & cur_ready;

  // Both operands sign-extended one bit so the sum cannot wrap.
  assign p_ext = {pot[ptr][WIDTH-1], pot[ptr]};
  assign c_ext = {cur_data[WIDTH-1], cur_data};
  assign calc  = p_ext - (p_ext >>> LEAK_SHIFT) + c_ext;

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] refr [N_NEURONS];

  assign in_refr = (refr[ptr] != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++)
        refr[i] <= '0;
    end else if (hs) begin
      if (in_refr)
        refr[ptr] <= refr[ptr] - 1'b1;
      else if (fire)
        refr[ptr] <= RW'(REFRAC_STEPS);
    end
  end
`else
  logic unused_refrac;
  assign unused_refrac = (REFRAC_STEPS != 0);
  assign in_refr = 1'b0;
`endif

  assign fire  = (calc >= THR) & ~in_refr;
  // Non-firing, non-negative results are below THRESHOLD, so they fit.
  assign p_new = (in_refr | fire | calc[WIDTH]) ?
                 '0 : calc[WIDTH-1:0];

  always_comb begin
    acc_next      = acc;
    acc_next[ptr] = fire;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_NEURONS; i++)
      cnt = cnt + (IDX_W+1)'(acc_next[i]);
  end

  always_comb begin
    rd_potential = '0;
    if ({1'b0, rd_idx} < (IDX_W+1)'(N_NEURONS))
      rd_potential = pot[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      acc         <= '0;
      step_done   <= 1'b0;
      spikes      <= '0;
      spike_count <= '0;
      for (int i = 0; i < N_NEURONS; i++)
        pot[i] <= '0;
    end else begin
      step_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (step_start) begin
            state <= RUN;
            ptr   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            pot[ptr] <= p_new;
            acc      <= acc_next;
            if (ptr == LAST) begin
              state       <= IDLE;
              ptr         <= '0;
              spikes      <= acc_next;
              spike_count <= cnt;
              step_done   <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array.
// Directed scenarios plus random steps against a behavioural model.
module tb_lif_neuron_array;

  localparam int N   = 16;
  localparam int W   = 16;
  localparam int THR = 1000;
  localparam int LS  = 3;
  localparam int RS  = 2;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_start = 1'b0;
  logic          cur_valid = 1'b0;
  logic          cur_ready;
  logic signed [W-1:0] cur_data = '0;
  logic          busy;
  logic [IW-1:0] cur_idx;
  logic          step_done;
  logic [N-1:0]  spikes;
  logic [IW:0]   spike_count;
  logic [IW-1:0] rd_idx = '0;
  logic signed [W-1:0] rd_potential;

  int n_cmp = 0;
  int n_bad = 0;
  int mpot [N];
  int mref [N];
  int cv [N];

  lif_neuron_array #(
    .N_NEURONS(N), .WIDTH(W), .THRESHOLD(THR),
    .LEAK_SHIFT(LS), .REFRAC_STEPS(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .step_start(step_start),
    .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cur_data(cur_data), .busy(busy),
    .cur_idx(cur_idx), .step_done(step_done),
    .spikes(spikes), .spike_count(spike_count),
    .rd_idx(rd_idx), .rd_potential(rd_potential)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mpot[i] = 0;
      mref[i] = 0;
    end
  endfunction

  // LIF rule on plain integers; potentials stay in [0, THR).
  function automatic bit model_hs(int i, int c);
    int calc;
`ifdef LIF_REFRACTORY_EN
    if (mref[i] > 0) begin
      mref[i]--;
      mpot[i] = 0;
      return 1'b0;
    end
`endif
    calc = mpot[i] - (mpot[i] / (1 << LS)) + c;
    if (calc >= THR) begin
      mpot[i] = 0;
      mref[i] = RS;
      return 1'b1;
    end
    mpot[i] = (calc < 0) ? 0 : calc;
    return 1'b0;
  endfunction

  task automatic chk_pots(string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
      check(tag, int'(rd_potential), mpot[i]);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step_start = 1'b0;
    cur_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_step(input bit stall,
                          output int spk);
    int exp_cnt;
    spk = 0;
    exp_cnt = 0;
    step_start = 1'b1;
    tick;
    step_start = 1'b0;
    check("ready_after_start", int'(cur_ready), 1);
    check("busy_in_run", int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      if (stall) begin
        cur_valid = 1'b0;
        step_start = 1'($urandom_range(0, 1));
        tick;
        step_start = 1'b0;
        check("idx_hold", int'(cur_idx), i);
      end
      cur_valid = 1'b1;
      cur_data = W'(cv[i]);
      check("cur_idx", int'(cur_idx), i);
      tick;
      cur_valid = 1'b0;
      if (model_hs(i, cv[i])) begin
        spk = spk | (1 << i);
        exp_cnt++;
      end
      rd_idx = IW'(i);
      #1;
      check("pot_after_hs", int'(rd_potential), mpot[i]);
    end
    check("step_done", int'(step_done), 1);
    check("spikes", int'(spikes), spk);
    check("spike_count", int'(spike_count), exp_cnt);
    check("busy_idle", int'(busy), 0);
    tick;
    check("done_pulse", int'(step_done), 0);
    check("spikes_hold", int'(spikes), spk);
    chk_pots("pots_end");
  endtask

  task automatic set_zero;
    for (int i = 0; i < N; i++)
      cv[i] = 0;
  endtask

  task automatic set_rand;
    for (int i = 0; i < N; i++)
      cv[i] = int'($urandom_range(0, 1000)) - 300;
  endtask

  initial begin
    int spk;
    bit exp_b;

    do_reset;
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cur_ready), 0);
    check("rst_done", int'(step_done), 0);
    check("rst_spikes", int'(spikes), 0);
    check("rst_count", int'(spike_count), 0);
    check("rst_idx", int'(cur_idx), 0);
    chk_pots("rst_pots");

    set_zero;
    run_step(1'b0, spk);
    check("zero_spikes", int'(spikes), 0);

    set_zero;
    cv[0] = -50;
    cv[1] = 999;
    cv[3] = 600;
    run_step(1'b0, spk);
    rd_idx = 3; #1;
    check("p3_600", int'(rd_potential), 600);
    rd_idx = 1; #1;
    check("p1_999", int'(rd_potential), 999);
    rd_idx = 0; #1;
    check("p0_clamp", int'(rd_potential), 0);
    check("no_fire_999", int'(spikes), 0);

    set_zero;
    cv[1] = 125;
    cv[3] = 600;
    run_step(1'b0, spk);
    check("fire_1000_1125", int'(spikes), 32'h000A);
    check("fire_count", int'(spike_count), 2);
    rd_idx = 3; #1;
    check("p3_reset", int'(rd_potential), 0);

    do_reset;
    for (int s = 0; s < 4; s++) begin
      set_zero;
      cv[5] = 1000;
      run_step(1'b0, spk);
`ifdef LIF_REFRACTORY_EN
      exp_b = (s == 0 || s == 3);
`else
      exp_b = 1'b1;
`endif
      check("refrac_bit5", int'(spikes[5]), int'(exp_b));
    end

    do_reset;
    for (int s = 0; s < 3; s++) begin
      set_rand;
      run_step(1'b1, spk);
    end

    step_start = 1'b1;
    tick;
    step_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cur_valid = 1'b1;
      cur_data = 16'sd900;
      tick;
    end
    cur_valid = 1'b0;
    check("mid_idx", int'(cur_idx), 5);
    do_reset;
    check("mrst_busy", int'(busy), 0);
    check("mrst_ready", int'(cur_ready), 0);
    check("mrst_spikes", int'(spikes), 0);
    check("mrst_count", int'(spike_count), 0);
    check("mrst_idx", int'(cur_idx), 0);
    chk_pots("mrst_pots");

    for (int s = 0; s < 15; s++) begin
      set_rand;
      run_step(1'($urandom_range(0, 1)), spk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath, with state held in internal register arrays. It is the parametrised successor of the single-neuron LIF block and sits between the synaptic accumulator, which streams one input current per neuron per timestep, and the spike router, which consumes the per-step spike vector. Each timestep is started explicitly and processes neurons 0..N_NEURONS-1 in order under a valid/ready handshake. An optional refractory period is available.

## Interface
- N_NEURONS, 16: number of neurons; ≥2. IDX_W = $clog2(N_NEURONS), derived.
- WIDTH, 16: signed potential and current width.
- THRESHOLD, 1000: firing threshold; positive, < 2^(WIDTH-1).
- LEAK_SHIFT, 3: leak term is potential >>> LEAK_SHIFT.
- REFRAC_STEPS, 2: refractory length in timesteps; used only with LIF_REFRACTORY_EN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous active-low.
- step_start  in  1  request one timestep; honoured only in IDLE.
- cur_valid  in  1  cur_data valid.
- cur_ready  out  1  block accepts a current.
- cur_data  in  WIDTH signed  input current for the neuron currently indexed.
- busy  out  1  FSM in RUN.
- cur_idx  out  IDX_W  index of the neuron awaiting a current.
- step_done  out  1  one-cycle pulse: step complete and spikes valid.
- spikes  out  N_NEURONS  fire vector of the last completed step; bit i = neuron i.
- spike_count  out  IDX_W+1  popcount of spikes.
- rd_idx  in  IDX_W  debug read index.
- rd_potential  out  WIDTH signed  combinational pot[rd_idx]; 0 if rd_idx ≥ N_NEURONS.

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN: on step_start; sets ptr=0 and clears the spike accumulator.
- RUN → IDLE: on the handshake with ptr = N_NEURONS-1.
- cur_ready = (state == RUN). cur_idx = ptr. busy = (state == RUN).
- Handshake = cur_valid & cur_ready. Each handshake updates neuron ptr, then ptr increments. cur_valid gaps stall the step without limit.
- Update arithmetic is computed at WIDTH+1 bits signed: calc = p − (p >>> LEAK_SHIFT) + cur_data, with both operands sign-extended.
- calc ≥ THRESHOLD: neuron fires, p ← 0, spike bit set.
- calc < 0: p ← 0, no fire.
- Otherwise: p ← calc[WIDTH-1:0]. The result fits in WIDTH because 0 ≤ calc < THRESHOLD.
- On the last handshake: spikes ← accumulator including the last neuron's bit; spike_count ← its popcount; step_done ← 1 for the next cycle.
- spikes and spike_count hold their values until the next step completes.
- step_start in RUN is ignored. step_start in the step_done cycle is accepted, because the FSM is already in IDLE.
- Potentials are only written on handshakes; there is no leak between steps.

## Timing
- Reset values: state IDLE, ptr 0, cur_ready 0, busy 0, step_done 0, spikes 0, spike_count 0. All potentials and refractory counters are 0.
- step_start at cycle t → cur_ready = 1 at t+1.
- Handshake at cycle t → pot[ptr] visible on rd_potential at t+1.
- Last handshake at cycle t → step_done, spikes and spike_count updated at t+1.
- Minimum step length is N_NEURONS+1 cycles from step_start to step_done.
- Reset asserted mid-step: the partial step is discarded, all state returns to reset values, and the next step starts at neuron 0.

## Configuration
- LIF_REFRACTORY_EN defined:
  - Each neuron has a counter of width $clog2(REFRAC_STEPS+1).
  - On fire, the counter is set to REFRAC_STEPS.
  - At a neuron's handshake with counter > 0: cur_data is ignored, p ← 0, no fire, and the counter decrements.
- LIF_REFRACTORY_EN undefined: no counters exist, REFRAC_STEPS has no effect, and every handshake applies the normal update.

## Test plan
- Zero input: reset, one step with 16 zero currents → spikes = 0, spike_count = 0, step_done exactly one cycle after the 16th handshake, all potentials 0.
- Integration and fire: neuron 3 gets 600 in two consecutive steps.
  - Step 1: p = 600, no spike.
  - Step 2: calc = 600 − 75 + 600 = 1125 → spikes = 0x0008, spike_count = 1, p3 = 0.
  - Separately, calc = 999 does not fire and calc = 1000 does.
- Negative clamp: neuron 0 at p = 0 receives −50 → p0 = 0, no spike.
- Backpressure and ignored start:
  - cur_valid asserted every other cycle → identical potentials and spikes to the unstalled run, and cur_idx advances only on handshakes.
  - step_start pulsed during RUN → no effect.
- Refractory, neuron 5, constant current 1000 each step:
  - Macro on, REFRAC_STEPS = 2: spikes on steps 1 and 4; on steps 2 and 3, p5 = 0 with no spike.
  - Macro off: a spike on every step.
- Reset mid-step: rst_n low after 5 handshakes → all outputs and potentials return to 0, and the next step starts at cur_idx = 0.
